// File: rtl/plantard_sched.sv
// plantard_sched: round-robin arbiter sharing one fixed-latency,
// fully pipelined Plantard reducer among NREQ requesters.
// Ports: clk, rst (sync, active-high); req_valid/req_a/req_q in,
// req_ready out (one-hot grant); hold blocks grants;
// red_valid/red_a/red_q issue to the reducer, red_t returns LAT
// cycles later; rsp_valid/rsp_id/rsp_t return the tagged result;
// idle is high when nothing is in flight.
module plantard_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*32-1:0] req_q,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               red_valid,
  output logic [63:0]        red_a,
  output logic [31:0]        red_q,
  input  logic [31:0]        red_t,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_t,
  output logic               idle
);

  localparam int CW = $clog2(LAT+3);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt;
  logic [IDW-1:0] red_id;
  logic [LAT-1:0] tv;
  logic [IDW-1:0] tid [LAT];
  logic [CW-1:0]  cnt;

  // Circular search starting at ptr; the sum is one bit wider
  // so the wrap works for non-power-of-two NREQ as well.
  always_comb begin
    logic [IDW:0]   s;
    logic [IDW-1:0] idx;
    gnt    = 1'b0;
    gnt_id = '0;
    s      = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      s = {1'b0, ptr} + (IDW+1)'(k);
      if (s >= (IDW+1)'(NREQ))
        s = s - (IDW+1)'(NREQ);
      idx = s[IDW-1:0];
      if (!gnt && req_valid[idx]) begin
        gnt    = 1'b1;
        gnt_id = idx;
      end
    end
    if (hold || rst)
      gnt = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (gnt)
      req_ready[gnt_id] = 1'b1;
  end

  assign idle = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      red_valid <= 1'b0;
      red_a     <= '0;
      red_q     <= '0;
      red_id    <= '0;
      tv        <= '0;
      for (int s = 0; s < LAT; s++)
        tid[s] <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_t     <= '0;
      cnt       <= '0;
    end else begin
      red_valid <= gnt;
      if (gnt) begin
        ptr    <= (gnt_id == IDW'(NREQ-1)) ?
                  '0 : gnt_id + IDW'(1);
        red_a  <= req_a[int'(gnt_id)*64 +: 64];
        red_q  <= req_q[int'(gnt_id)*32 +: 32];
        red_id <= gnt_id;
      end

      // Tag shift register mirrors the reducer pipeline:
      // the last stage lines up with red_t.
      tv[0]  <= red_valid;
      tid[0] <= red_id;
      for (int s = 1; s < LAT; s++) begin
        tv[s]  <= tv[s-1];
        tid[s] <= tid[s-1];
      end

      rsp_valid <= tv[LAT-1];
      if (tv[LAT-1]) begin
        rsp_id <= tid[LAT-1];
        rsp_t  <= red_t;
      end

      case ({gnt, rsp_valid})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_plantard_sched.sv
// tb_plantard_sched: randomized and directed bench for plantard_sched
// with a behavioural fixed-latency reducer and a scoreboard model.
module tb_plantard_sched;

  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int IDW = 2;

  localparam logic [63:0] VA = 64'd10492565405858659259;
  localparam logic [31:0] VQ = 32'd1073692673;
  localparam logic [31:0] VT = 32'h255c3d81;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hold = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*64-1:0]  req_a = '0;
  logic [N*32-1:0]  req_q = '0;
  logic [N-1:0]     req_ready;
  logic             red_valid;
  logic [63:0]      red_a;
  logic [31:0]      red_q;
  logic [31:0]      red_t;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [31:0]      rsp_t;
  logic             idle;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  plantard_sched #(.NREQ(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_q(req_q),
    .req_ready(req_ready), .hold(hold),
    .red_valid(red_valid), .red_a(red_a), .red_q(red_q),
    .red_t(red_t),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_t(rsp_t),
    .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in for the reducer arithmetic: the shared vector gives
  // its known Plantard result, anything else a cheap mixing hash.
  function automatic logic [31:0] redf(logic [63:0] a, logic [31:0] q);
    if (a == VA && q == VQ)
      return VT;
    return a[31:0] ^ a[63:32] ^ {q[15:0], q[31:16]};
  endfunction

  logic [31:0] rp [LAT];
  always @(posedge clk) begin
    rp[0] <= redf(red_a, red_q);
    for (int i = 1; i < LAT; i++)
      rp[i] <= rp[i-1];
  end
  assign red_t = rp[LAT-1];

  // Scoreboard model
  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    t;
    int             due;
  } exp_t;

  exp_t        rq [$];
  int          mptr = 0;
  int          mcnt = 0;
  logic        ev = 1'b0;
  logic [63:0] ea = '0;
  logic [31:0] eq = '0;

  always @(negedge clk) begin
    int           g;
    logic         rn;
    logic [N-1:0] er;
    exp_t         e;
    nchk++;
    if (red_valid !== ev) begin
      nerr++;
      $display("FAIL mon_red_valid: got %0b want %0b cyc %0d",
               red_valid, ev, cyc);
    end
    nchk++;
    if (red_a !== ea || red_q !== eq) begin
      nerr++;
      $display("FAIL mon_red_data: got %h/%h want %h/%h cyc %0d",
               red_a, red_q, ea, eq, cyc);
    end
    rn = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      rn = 1'b1;
      nchk++;
      if (rsp_valid !== 1'b1 || rsp_id !== rq[0].id ||
          rsp_t !== rq[0].t) begin
        nerr++;
        $display("FAIL mon_rsp: got v%0b id%0d %h want v1 id%0d %h cyc %0d",
                 rsp_valid, rsp_id, rsp_t, rq[0].id, rq[0].t, cyc);
      end
      void'(rq.pop_front());
    end else begin
      nchk++;
      if (rsp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL mon_rsp_idle: got rsp_valid %0b want 0 cyc %0d",
                 rsp_valid, cyc);
      end
    end
    nchk++;
    if (idle !== (mcnt == 0)) begin
      nerr++;
      $display("FAIL mon_idle: got %0b want %0b cyc %0d",
               idle, (mcnt == 0), cyc);
    end
    g = -1;
    if (!rst && !hold)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(mptr+k)%N])
          g = (mptr + k) % N;
    er = '0;
    if (g >= 0)
      er[g] = 1'b1;
    nchk++;
    if (req_ready !== er) begin
      nerr++;
      $display("FAIL mon_grant: got %b want %b cyc %0d",
               req_ready, er, cyc);
    end
    if (rst) begin
      ev   = 1'b0;
      ea   = '0;
      eq   = '0;
      mptr = 0;
      mcnt = 0;
      rq.delete();
    end else begin
      ev = (g >= 0);
      if (g >= 0) begin
        ea    = req_a[g*64 +: 64];
        eq    = req_q[g*32 +: 32];
        mptr  = (g + 1) % N;
        e.id  = IDW'(g);
        e.t   = redf(ea, eq);
        e.due = cyc + LAT + 2;
        rq.push_back(e);
      end
      mcnt = mcnt + ((g >= 0) ? 1 : 0) - (rn ? 1 : 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic rand_ops;
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = {$urandom, $urandom};
      req_q[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hold = 1'b0;
    req_valid = '1;
    rand_ops();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (req_ready !== '0 || red_valid !== 1'b0 ||
          rsp_valid !== 1'b0 || rsp_t !== '0 || idle !== 1'b1) begin
        nerr++;
        $display("FAIL reset_outputs: got rdy %b rv %0b sv %0b t %h idle %0b want 0 0 0 0 1",
                 req_ready, red_valid, rsp_valid, rsp_t, idle);
      end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    nchk++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_single;
    drain(12);
    req_a[2*64 +: 64] = VA;
    req_q[2*32 +: 32] = VQ;
    req_valid = 4'b0100;
    @(negedge clk);
    nchk++;
    if (req_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL single_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    for (int d = 1; d <= 7; d++) begin
      @(negedge clk);
      if (d == 1) begin
        nchk++;
        if (red_valid !== 1'b1 || red_a !== VA || red_q !== VQ) begin
          nerr++;
          $display("FAIL single_issue: got %0b %h %h want 1 %h %h",
                   red_valid, red_a, red_q, VA, VQ);
        end
      end
      if (d <= 6) begin
        nchk++;
        if (idle !== 1'b0) begin
          nerr++;
          $display("FAIL single_busy: got idle %0b want 0 at k+%0d",
                   idle, d);
        end
      end
      if (d == 6) begin
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_t !== VT) begin
          nerr++;
          $display("FAIL single_rsp: got %0b id%0d %h want 1 id2 %h",
                   rsp_valid, rsp_id, rsp_t, VT);
        end
      end
      if (d == 7) begin
        nchk++;
        if (idle !== 1'b1) begin
          nerr++;
          $display("FAIL single_idle: got %0b want 1", idle);
        end
      end
    end
    tick();
  endtask

  task automatic test_contention;
    int           s;
    logic [N-1:0] er;
    drain(2);
    rand_ops();
    s = mptr;
    req_valid = '1;
    for (int j = 0; j < 12; j++) begin
      er = '0;
      er[(s+j)%N] = 1'b1;
      @(negedge clk);
      nchk++;
      if (req_ready !== er) begin
        nerr++;
        $display("FAIL contention_rot: got %b want %b step %0d",
                 req_ready, er, j);
      end
      tick();
      req_a[((s+j)%N)*64 +: 64] = {$urandom, $urandom};
    end
    req_valid = '0;
    drain(8);
  endtask

  task automatic test_sparse_wrap;
    logic [N-1:0] seq [4];
    logic [N-1:0] vin [4];
    seq[0] = 4'b0010; vin[0] = 4'b0010;
    seq[1] = 4'b1000; vin[1] = 4'b1010;
    seq[2] = 4'b0010; vin[2] = 4'b1010;
    seq[3] = 4'b0100; vin[3] = 4'b1111;
    rand_ops();
    for (int j = 0; j < 4; j++) begin
      req_valid = vin[j];
      @(negedge clk);
      nchk++;
      if (req_ready !== seq[j]) begin
        nerr++;
        $display("FAIL sparse_wrap: got %b want %b step %0d",
                 req_ready, seq[j], j);
      end
      tick();
    end
    req_valid = '0;
    drain(8);
  endtask

  task automatic test_hold_drain;
    int           pulses;
    logic [N-1:0] er;
    rand_ops();
    req_valid = '1;
    drain(3);
    hold = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nchk++;
      if (req_ready !== '0) begin
        nerr++;
        $display("FAIL hold_block: got %b want 0000 step %0d",
                 req_ready, i);
      end
      if (rsp_valid === 1'b1)
        pulses++;
      tick();
    end
    @(negedge clk);
    nchk++;
    if (pulses != 3 || idle !== 1'b1) begin
      nerr++;
      $display("FAIL hold_drain: got %0d pulses idle %0b want 3 1",
               pulses, idle);
    end
    tick();
    hold = 1'b0;
    er = '0;
    er[mptr] = 1'b1;
    @(negedge clk);
    nchk++;
    if (req_ready !== er) begin
      nerr++;
      $display("FAIL hold_release: got %b want %b", req_ready, er);
    end
    tick();
    req_valid = '0;
    drain(8);
  endtask

  task automatic test_reset_mid;
    rand_ops();
    req_valid = '1;
    drain(3);
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int d = 0; d < LAT + 2; d++) begin
      @(negedge clk);
      nchk++;
      if (rsp_valid !== 1'b0) begin
        nerr++;
        $display("FAIL midreset_rsp: got %0b want 0 step %0d",
                 rsp_valid, d);
      end
      if (d == 0) begin
        nchk++;
        if (idle !== 1'b1) begin
          nerr++;
          $display("FAIL midreset_idle: got %0b want 1", idle);
        end
      end
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    nchk++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL midreset_ptr: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    drain(8);
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom);
      hold = ($urandom_range(0, 9) == 0);
      rand_ops();
      tick();
    end
    req_valid = '0;
    hold = 1'b0;
    drain(10);
    @(negedge clk);
    nchk++;
    if (idle !== 1'b1) begin
      nerr++;
      $display("FAIL random_idle: got %0b want 1", idle);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_sparse_wrap();
    test_hold_drain();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
